frv_pipeline_fifo: RTL and testbench
====================================

# frv_pipeline_fifo

Parametrised elastic buffer placed between two pipeline stages (e.g. execute → memory/writeback). It generalises the single-entry stage register to a DEPTH-entry circular buffer of RLEN-bit payloads, using the same valid/busy handshake on both sides. It decouples stage N from short stalls in stage N+1, exposes its occupancy, and supports a single-cycle flush. An optional zero-latency bypass is selected at compile time.

## Interface
Parameters:
- RLEN, 8, payload width in bits (≥1).
- DEPTH, 2, number of storage entries (≥1; any integer, not only powers of two).
- CW, $clog2(DEPTH+1), occupancy counter width (derived; not overridden).

Ports:
- g_clk  in  1  global clock; all state updates on its rising edge.
- g_reset  in  1  synchronous reset, active-high.
- flush  in  1  discard all stored and in-flight entries.
- i_data  in  RLEN  payload from stage N.
- i_valid  in  1  stage N presents a payload.
- o_busy  out  1  buffer cannot accept this cycle.
- mr_data  out  RLEN  most recently accepted payload.
- o_data  out  RLEN  payload to stage N+1.
- o_valid  out  1  o_data is valid.
- i_busy  in  1  stage N+1 cannot accept this cycle.
- count  out  CW  number of stored entries.

## Operation
- Push when i_valid && !o_busy && !flush. Pop when o_valid && !i_busy && !flush.
- Storage: mem[0..DEPTH-1], wr_ptr and rd_ptr wrap from DEPTH-1 to 0. count increments on push-only, decrements on pop-only, and is unchanged on simultaneous push and pop.
- o_busy = (count == DEPTH). It depends only on registered state and never on i_busy. When full, no push occurs even if a pop happens in the same cycle.
- o_valid = (count != 0), plus the bypass term when configured. o_data = mem[rd_ptr] when count != 0.
- mr_data updates to i_data on every push, including bypassed pushes. flush does not clear it; only reset does.
- flush: in the flush cycle o_valid is forced 0 and nothing pushes or pops. On the next cycle count, wr_ptr and rd_ptr are 0. flush takes priority over every other event.
- Reset values: count=0, o_valid=0, o_busy=0, o_data=0, mr_data=0, pointers=0, all mem entries=0.
- Payload order is strictly FIFO. No payload is ever duplicated or dropped, except by flush.

## Timing
- Without bypass, a payload pushed in cycle t appears on o_data with o_valid=1 in cycle t+1 at the earliest.
- Full throughput: one push and one pop per cycle are sustained when 0<count<DEPTH. With DEPTH=1 and no bypass, throughput is one payload every 2 cycles under continuous traffic.
- o_busy rises in the cycle after the push that fills the buffer. It falls in the cycle after the first pop from full.
- Reset asserted mid-operation discards all contents, identically to flush, and additionally clears mr_data. Outputs show reset values in the cycle after g_reset is sampled high.

## Configuration
- FRV_PIPE_FIFO_BYPASS_EN defined:
  - When count==0 and i_valid && !flush, then o_valid=1 and o_data=i_data combinationally.
  - If i_busy=0 as well, the payload passes straight through. count and pointers stay unchanged, and mr_data updates.
  - If i_busy=1, the payload is stored normally.
  - Latency is 0 cycles when empty. This creates a combinational path i_valid/i_data → o_valid/o_data.
- FRV_PIPE_FIFO_BYPASS_EN undefined: no combinational input-to-output path. Minimum latency is 1 cycle.

## Test plan
- Reset, then idle; RLEN=8, DEPTH=2. Required: o_valid=0, o_busy=0, count=0, o_data=0 and mr_data=0 for 5 cycles.
- Fill with i_busy=1: push 0x11, 0x22. Required: count goes 1 then 2, and o_busy=1 from the cycle after the second push. A third i_valid with 0x33 is not accepted. Release i_busy: outputs are 0x11 then 0x22, then o_busy=0 and count=0.
- Streaming with i_busy=0, i_valid held, payloads 0x01..0x10: all 16 values emerge in order, one per cycle after the first. Without bypass the first output appears 1 cycle after the first push; with bypass, in the same cycle.
- Wrap-around with DEPTH=3: interleave pushes and pops for 10 payloads with pointers crossing 2→0 at least three times. Required: output order matches input order and count never exceeds 3.
- Flush with count=2 while i_valid=1 carrying 0x44: the cycle after, count=0 and o_valid=0; 0x44 is not stored; mr_data keeps its last pushed value.
- Reset mid-stream with count=1 and g_reset=1 for one cycle: the next cycle shows all outputs at their reset values, including mr_data=0.

Source files
------------

// File: rtl/frv_pipeline_fifo.sv
// Elastic DEPTH-entry FIFO between two pipeline stages using a valid/busy handshake on both sides.
// Define FRV_PIPE_FIFO_BYPASS_EN to let a payload reach an empty buffer's output in the same cycle.
module frv_pipeline_fifo #(
  parameter int RLEN  = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            flush,
  input  logic [RLEN-1:0] i_data,
  input  logic            i_valid,
  output logic            o_busy,
  output logic [RLEN-1:0] mr_data,
  output logic [RLEN-1:0] o_data,
  output logic            o_valid,
  input  logic            i_busy,
  output logic [CW-1:0]   count
);

  localparam int            PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C = PW'(DEPTH - 1);

  logic [RLEN-1:0] mem_q [DEPTH];
  logic [RLEN-1:0] mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [RLEN-1:0] mr_data_q, mr_data_d;

  logic empty;
  logic full;
  logic byp_valid;
  logic push;
  logic pop;
  logic store;
  logic drain;

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == FULL_C);
`ifdef FRV_PIPE_FIFO_BYPASS_EN
    byp_valid = empty && i_valid && !flush;
`else
    byp_valid = 1'b0;
`endif
    o_busy  = full;
    o_valid = !flush && (!empty || byp_valid);
`ifdef FRV_PIPE_FIFO_BYPASS_EN
    if (!empty) begin
      o_data = mem_q[rd_ptr_q];
    end else if (byp_valid) begin
      o_data = i_data;
    end else begin
      o_data = '0;
    end
`else
    o_data = empty ? '0 : mem_q[rd_ptr_q];
`endif
    push  = i_valid && !full && !flush;
    pop   = o_valid && !i_busy;
    // A bypassed payload is consumed in the same cycle and never touches storage.
    store = push && !(byp_valid && pop);
    drain = pop && !empty;
  end

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    mr_data_d = mr_data_q;

    if (push) begin
      mr_data_d = i_data;
    end
    if (store) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + PW'(1);
    end
    if (drain) begin
      rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + PW'(1);
    end

    case ({store, drain})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Storage contents are left in place on flush; resetting the pointers is enough.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      mr_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      mr_data_q <= mr_data_d;
    end
  end

  assign count   = count_q;
  assign mr_data = mr_data_q;

endmodule

// File: tb/tb_frv_pipeline_fifo.sv
// Randomised and directed bench for frv_pipeline_fifo: instance 0 has DEPTH=2, instance 1 has DEPTH=3.
// Both are compared every cycle against a queue-based reference model.
module tb_frv_pipeline_fifo;

`ifdef FRV_PIPE_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       g_clk = 1'b0;
  logic       g_reset;
  logic       flush   [2];
  logic       i_valid [2];
  logic       i_busy  [2];
  logic [7:0] i_data  [2];
  logic       o_busy  [2];
  logic       o_valid [2];
  logic [7:0] o_data  [2];
  logic [7:0] mr_data [2];
  logic [1:0] count   [2];

  always #5 g_clk = ~g_clk;

  frv_pipeline_fifo #(.RLEN(8), .DEPTH(2)) u_dut0 (
    .g_clk(g_clk), .g_reset(g_reset), .flush(flush[0]), .i_data(i_data[0]),
    .i_valid(i_valid[0]), .o_busy(o_busy[0]), .mr_data(mr_data[0]), .o_data(o_data[0]),
    .o_valid(o_valid[0]), .i_busy(i_busy[0]), .count(count[0])
  );

  frv_pipeline_fifo #(.RLEN(8), .DEPTH(3)) u_dut1 (
    .g_clk(g_clk), .g_reset(g_reset), .flush(flush[1]), .i_data(i_data[1]),
    .i_valid(i_valid[1]), .o_busy(o_busy[1]), .mr_data(mr_data[1]), .o_data(o_data[1]),
    .o_valid(o_valid[1]), .i_busy(i_busy[1]), .count(count[1])
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [7:0] q0[$], q1[$];
  logic [7:0] rx0[$], rx1[$];
  logic [7:0] mr_m     [2];
  bit         known    [2];
  int         first_rx [2];
  int         last_rx  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [7:0] qfront(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int k);
    if (k == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic qpush(input int k, input logic [7:0] v);
    if (k == 0) q0.push_back(v);
    else        q1.push_back(v);
  endtask

  task automatic qclear(input int k);
    if (k == 0) q0.delete();
    else        q1.delete();
  endtask

  task automatic rxpush(input int k, input logic [7:0] v);
    if (k == 0) rx0.push_back(v);
    else        rx1.push_back(v);
    if (first_rx[k] < 0) first_rx[k] = cyc;
    last_rx[k] = cyc;
  endtask

  // Checks this cycle's outputs against the model, then advances the model by one clock.
  task automatic model_cycle(input int k);
    int         n;
    int         depth;
    bit         busy_e, valid_e, acc, take;
    logic [7:0] front;
    depth   = (k == 0) ? 2 : 3;
    n       = qsize(k);
    front   = (n > 0) ? qfront(k) : 8'h00;
    busy_e  = (n == depth);
    valid_e = !flush[k] && ((n > 0) || (BYP && i_valid[k]));
    if (known[k]) begin
      chk($sformatf("count%0d", k), 32'(count[k]), n);
      chk($sformatf("busy%0d", k), 32'(o_busy[k]), 32'(busy_e));
      chk($sformatf("valid%0d", k), 32'(o_valid[k]), 32'(valid_e));
      chk($sformatf("mr%0d", k), 32'(mr_data[k]), 32'(mr_m[k]));
      if (valid_e) chk($sformatf("data%0d", k), 32'(o_data[k]), 32'((n > 0) ? front : i_data[k]));
    end
    if (o_valid[k] === 1'b1 && !i_busy[k] && !flush[k] && !g_reset) rxpush(k, o_data[k]);
    if (g_reset) begin
      qclear(k);
      mr_m[k]  = 8'h00;
      known[k] = 1'b1;
    end else if (flush[k]) begin
      qclear(k);
    end else begin
      acc  = i_valid[k] && !busy_e;
      take = valid_e && !i_busy[k];
      if (take && n > 0) qpop(k);
      if (acc) begin
        mr_m[k] = i_data[k];
        if (!(take && n == 0)) qpush(k, i_data[k]);
      end
    end
  endtask

  task automatic step();
    @(negedge g_clk);
    model_cycle(0);
    model_cycle(1);
    @(posedge g_clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      flush[k]   = 1'b0;
      i_valid[k] = 1'b0;
      i_busy[k]  = 1'b0;
      i_data[k]  = 8'h00;
    end
  endtask

  initial begin
    int         v, start, sent, budget;
    bit         acc;
    logic [7:0] sent_v[$];

    idle();
    known    = '{1'b0, 1'b0};
    first_rx = '{-1, -1};
    last_rx  = '{-1, -1};
    g_reset  = 1'b1;
    step();
    step();
    g_reset = 1'b0;

    // Idle after reset
    repeat (5) begin
      step();
      chk("rst_valid", 32'(o_valid[0]), 0);
      chk("rst_busy", 32'(o_busy[0]), 0);
      chk("rst_count", 32'(count[0]), 0);
      chk("rst_data", 32'(o_data[0]), 0);
      chk("rst_mr", 32'(mr_data[0]), 0);
    end

    // Fill DEPTH=2 with downstream stalled
    rx0.delete();
    i_busy[0] = 1'b1; i_valid[0] = 1'b1; i_data[0] = 8'h11;
    step();
    chk("fill_count1", 32'(count[0]), 1);
    i_data[0] = 8'h22;
    step();
    chk("fill_count2", 32'(count[0]), 2);
    chk("fill_busy", 32'(o_busy[0]), 1);
    i_data[0] = 8'h33;
    step();
    chk("fill_reject", 32'(count[0]), 2);
    chk("fill_mr", 32'(mr_data[0]), 32'h22);
    i_valid[0] = 1'b0; i_busy[0] = 1'b0;
    #1;
    chk("drain_first", 32'(o_data[0]), 32'h11);
    step();
    chk("drain_second", 32'(o_data[0]), 32'h22);
    step();
    chk("drain_busy", 32'(o_busy[0]), 0);
    chk("drain_count", 32'(count[0]), 0);
    chk("drain_rxn", rx0.size(), 2);

    // Streaming 0x01..0x10 with i_valid held
    rx0.delete();
    first_rx[0] = -1;
    start = cyc;
    v = 1;
    budget = 0;
    i_valid[0] = 1'b1;
    while (v <= 16 && budget < 100) begin
      i_data[0] = 8'(v);
      acc = (qsize(0) < 2);
      step();
      if (acc) v++;
      budget++;
    end
    i_valid[0] = 1'b0;
    budget = 0;
    while (rx0.size() < 16 && budget < 20) begin
      step();
      budget++;
    end
    chk("stream_n", rx0.size(), 16);
    for (int i = 0; i < 16 && i < rx0.size(); i++) chk($sformatf("stream_%0d", i), 32'(rx0[i]), i + 1);
    chk("stream_lat", first_rx[0] - start, BYP ? 0 : 1);
    chk("stream_rate", last_rx[0] - first_rx[0], 15);

    // Wrap-around on DEPTH=3 with random handshakes
    rx1.delete();
    sent = 0;
    budget = 0;
    while (rx1.size() < 10 && budget < 400) begin
      i_valid[1] = (sent < 10) && ($urandom_range(0, 3) != 0);
      i_data[1]  = 8'($urandom);
      i_busy[1]  = 1'($urandom_range(0, 1));
      acc = i_valid[1] && (qsize(1) < 3);
      step();
      if (acc) begin
        sent_v.push_back(i_data[1]);
        sent++;
      end
      budget++;
    end
    idle();
    chk("wrap_n", rx1.size(), 10);
    for (int i = 0; i < 10 && i < rx1.size() && i < sent_v.size(); i++)
      chk($sformatf("wrap_%0d", i), 32'(rx1[i]), 32'(sent_v[i]));

    // Flush with two entries while a new payload is offered
    i_busy[0] = 1'b1; i_valid[0] = 1'b1; i_data[0] = 8'hAA;
    step();
    i_data[0] = 8'hBB;
    step();
    chk("flush_pre", 32'(count[0]), 2);
    flush[0] = 1'b1; i_data[0] = 8'h44;
    step();
    idle();
    #1;
    chk("flush_count", 32'(count[0]), 0);
    chk("flush_valid", 32'(o_valid[0]), 0);
    chk("flush_mr", 32'(mr_data[0]), 32'hBB);
    step();
    chk("flush_nostore", 32'(count[0]), 0);

    // Random traffic on both instances with occasional flush
    repeat (400) begin
      for (int k = 0; k < 2; k++) begin
        i_valid[k] = 1'($urandom_range(0, 1));
        i_busy[k]  = ($urandom_range(0, 2) == 0);
        i_data[k]  = 8'($urandom);
        flush[k]   = ($urandom_range(0, 15) == 0);
      end
      step();
    end
    idle();

    // Reset mid-stream with one entry stored
    flush[0] = 1'b1; flush[1] = 1'b1;
    step();
    idle();
    i_valid[0] = 1'b1; i_data[0] = 8'h5A;
    step();
    i_valid[0] = 1'b0;
    #1;
    chk("mid_count", 32'(count[0]), 1);
    g_reset = 1'b1; i_valid[0] = 1'b1; i_data[0] = 8'h77;
    step();
    g_reset = 1'b0;
    idle();
    #1;
    chk("mreset_count", 32'(count[0]), 0);
    chk("mreset_valid", 32'(o_valid[0]), 0);
    chk("mreset_busy", 32'(o_busy[0]), 0);
    chk("mreset_data", 32'(o_data[0]), 0);
    chk("mreset_mr", 32'(mr_data[0]), 0);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
